uart_rx_param: RTL



---
 rtl/uart_rx_param.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// Oversampled UART receiver with configurable data width, parity and stop bits.
// Optional break detection: define UART_RX_BREAK_DETECT_EN.
module uart_rx_param #(
    parameter int unsigned CLOCK_HZ   = 10_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Rx_i,
    output logic                 Done_o,
    output logic [DATA_BITS-1:0] Data_o,
    output logic                 ParityError_o,
    output logic                 FrameError_o,
    output logic                 Busy_o,
    output logic                 Break_o
);
    localparam int unsigned TICKS_RAW = CLOCK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned TICKS     = (TICKS_RAW < 1) ? 1 : TICKS_RAW;
    localparam int unsigned TICK_W    = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int unsigned SAMPLE_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W     = $clog2(DATA_BITS);
    localparam int unsigned S_LO      = OVERSAMPLE / 2 - 1;
    localparam int unsigned S_MID     = OVERSAMPLE / 2;
    localparam int unsigned S_HI      = OVERSAMPLE / 2 + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

    state_t                 state;
    logic                   rx_s1, rx_s2, rx_prev;
    logic [TICK_W-1:0]      tick_cnt;
    logic [SAMPLE_W-1:0]    sample_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   stop_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   smp0, smp1, par_bit, ferr;
    logic                   fall_c, tick_c, decide_c, vote_c, par_err_c;

    assign fall_c   = rx_prev & ~rx_s2;
    assign tick_c   = (state != IDLE) && (tick_cnt == '0);
    assign decide_c = tick_c && (sample_cnt == SAMPLE_W'(S_HI));
    // Third sample is taken live on the decision tick.
    assign vote_c   = (smp0 & smp1) | (smp0 & rx_s2) | (smp1 & rx_s2);

    always_comb begin
        par_err_c = 1'b0;
        if (PARITY == 1)      par_err_c = ~(^shreg ^ par_bit);
        else if (PARITY == 2) par_err_c = ^shreg ^ par_bit;
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic brk_c;
    assign brk_c = (shreg == '0) && ((PARITY == 0) || !par_bit) && !vote_c && !stop_cnt;
`else
    assign Break_o = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            rx_prev       <= 1'b1;
            tick_cnt      <= '0;
            sample_cnt    <= '0;
            bit_cnt       <= '0;
            stop_cnt      <= 1'b0;
            shreg         <= '0;
            smp0          <= 1'b0;
            smp1          <= 1'b0;
            par_bit       <= 1'b0;
            ferr          <= 1'b0;
            Done_o        <= 1'b0;
            Data_o        <= '0;
            ParityError_o <= 1'b0;
            FrameError_o  <= 1'b0;
            Busy_o        <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            Break_o       <= 1'b0;
`endif
        end else begin
            rx_s1   <= Rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            Done_o  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            Break_o <= 1'b0;
`endif
            // Bit timing runs only inside a frame and restarts at phase 0 on each start edge.
            if (state == IDLE) begin
                tick_cnt   <= '0;
                sample_cnt <= '0;
            end else begin
                tick_cnt <= (tick_cnt == TICK_W'(TICKS - 1)) ? '0 : tick_cnt + TICK_W'(1);
                if (tick_c)
                    sample_cnt <= (sample_cnt == SAMPLE_W'(OVERSAMPLE - 1)) ? '0
                                                                           : sample_cnt + SAMPLE_W'(1);
                if (tick_c && sample_cnt == SAMPLE_W'(S_LO))  smp0 <= rx_s2;
                if (tick_c && sample_cnt == SAMPLE_W'(S_MID)) smp1 <= rx_s2;
            end

            case (state)
                IDLE: begin
                    Busy_o <= 1'b0;
                    if (fall_c) begin
                        state    <= START;
                        Busy_o   <= 1'b1;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        ferr     <= 1'b0;
                    end
                end
                START: if (decide_c) begin
                    if (vote_c) begin
                        state  <= IDLE;
                        Busy_o <= 1'b0;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (decide_c) begin
                    shreg <= {vote_c, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt <= '0;
                        state   <= (PARITY == 0) ? STOP : PAR;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                PAR: if (decide_c) begin
                    par_bit <= vote_c;
                    state   <= STOP;
                end
                STOP: if (decide_c) begin
`ifdef UART_RX_BREAK_DETECT_EN
                    if (brk_c) begin
                        Done_o        <= 1'b1;
                        Break_o       <= 1'b1;
                        Data_o        <= '0;
                        ParityError_o <= par_err_c;
                        FrameError_o  <= 1'b1;
                        state         <= WAIT_HIGH;
                    end else
`endif
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        Done_o        <= 1'b1;
                        Data_o        <= shreg;
                        ParityError_o <= par_err_c;
                        FrameError_o  <= ferr | ~vote_c;
                        state         <= IDLE;
                    end else begin
                        ferr     <= ~vote_c;
                        stop_cnt <= 1'b1;
                    end
                end
`ifdef UART_RX_BREAK_DETECT_EN
                // Leave only after the line has been high for one full bit period.
                WAIT_HIGH: begin
                    if (!rx_s2) begin
                        tick_cnt   <= '0;
                        sample_cnt <= '0;
                    end else if (tick_cnt == TICK_W'(TICKS - 1) &&
                                 sample_cnt == SAMPLE_W'(OVERSAMPLE - 1)) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
